mc_alu: RTL

Parametrised multi-cycle ALU for the datapath execute stage, next generation of the single-cycle 3-bit-opcode ALU. Operand width is a parameter. The block adds an iterative shift-add multiplier that returns the full double-width product, plus optional iterative division. Requests and responses use valid/ready handshakes, so the pipeline stalls while a multi-cycle op is in flight. Zero and signed-overflow flags are real, not tied off.

---
 rtl/mc_alu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic ops, iterative shift-add multiply, valid/ready handshakes.
// Define MC_ALU_DIV_EN to build the iterative unsigned divider behind opcode 111.
module mc_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] data_hi_o,
  output logic             Zero_o,
  output logic             Ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
`ifdef MC_ALU_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b111;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] iter_next;

  assign req_ready_o = (state == IDLE);

  always_comb begin
    add_res = data1_i + data2_i;
    sub_res = data1_i - data2_i;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUCtrl_i)
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                  (add_res[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                  (sub_res[WIDTH-1] != data1_i[WIDTH-1]);
      end
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: alu_res = '0;
    endcase
  end

  // acc = {partial product, remaining multiplier bits}; the carry of each add shifts in at the top.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MC_ALU_DIV_EN
  logic               div_mode;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  // acc = {remainder, dividend bits still to consume / quotient bits produced}; a borrow means restore.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    iter_next = div_mode ? div_next : mul_next;
  end
`else
  always_comb begin
    iter_next = mul_next;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      a_q          <= '0;
      acc          <= '0;
      resp_valid_o <= 1'b0;
      data_o       <= '0;
      data_hi_o    <= '0;
      Zero_o       <= 1'b1;
      Ovf_o        <= 1'b0;
`ifdef MC_ALU_DIV_EN
      div_mode     <= 1'b0;
      b_q          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            a_q <= data1_i;
            cnt <= CNT_W'(WIDTH);
            if (ALUCtrl_i == OP_MUL) begin
              acc   <= {{WIDTH{1'b0}}, data2_i};
              state <= BUSY;
`ifdef MC_ALU_DIV_EN
              div_mode <= 1'b0;
            end else if (ALUCtrl_i == OP_DIV) begin
              acc      <= {{WIDTH{1'b0}}, data1_i};
              b_q      <= data2_i;
              div_mode <= 1'b1;
              state    <= BUSY;
`endif
            end else begin
              data_o       <= alu_res;
              data_hi_o    <= '0;
              Zero_o       <= (alu_res == '0);
              Ovf_o        <= alu_ovf;
              resp_valid_o <= 1'b1;
              state        <= DONE;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          acc <= iter_next;
          if (cnt == CNT_W'(1)) begin
            data_o       <= iter_next[WIDTH-1:0];
            data_hi_o    <= iter_next[2*WIDTH-1:WIDTH];
            Zero_o       <= (iter_next[WIDTH-1:0] == '0);
            Ovf_o        <= 1'b0;
            resp_valid_o <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
